instr_mem: RTL and testbench
============================

INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have the following parameters (name, default, meaning), one per line:
- DEPTH, 256, number of 32-bit data-memory words; power of two.
- DATA_WIDTH, 32, datapath width.
- ADDR_WIDTH, 32, address/PC width.
REQ-002 SHALL have the following ports (name, direction, width, meaning), one per line:
- clk_87, in, 1, single clock; all state updates on rising edge.
- rst_87, in, 1, asynchronous active-high reset.
- alu_out_87, in, DATA_WIDTH, EX result / memory byte address.
- rval_b_87, in, DATA_WIDTH, store data.
- wreg_87, in, 5, destination register from EX.
- reg_write_87, mem_to_reg_87, mem_read_87, mem_write_87, branch_87, zero_87: in, 1 each, EX control bits.
- pc_brnch_87, in, ADDR_WIDTH, branch target from EX.
- pc_src_87, out, 1, branch taken to fetch.
- pc_tgt_87, out, ADDR_WIDTH, branch target to fetch.
- fwd_reg_87, fwd_val_87, fwd_en_87: out, 5/DATA_WIDTH/1, EX/MEM forwarding source.
- reg_2_write_87, data_2_write_87, en_wb_87: out, 5/DATA_WIDTH/1, writeback to decode register file.
- mem_err_87, out, 1, sticky misaligned-access flag.

Function
REQ-003 SHALL capture all EX inputs into an internal EX/MEM register on each rising edge; latency input->EX/MEM = 1 edge.
REQ-004 SHALL drive pc_src_87 = EX/MEM branch AND EX/MEM zero, and pc_tgt_87 = EX/MEM pc_brnch, combinationally from the EX/MEM register.
REQ-005 SHALL drive fwd_reg_87/fwd_val_87 from EX/MEM wreg/alu_out, and fwd_en_87 = EX/MEM reg_write AND NOT mem_to_reg AND (wreg != 0).
REQ-006 SHALL index memory with alu_out[log2(DEPTH)+1:2]; upper address bits are ignored (address wraps modulo DEPTH*4).
REQ-007 SHALL write rval_b to the indexed word at the edge ending the cycle in which EX/MEM mem_write=1.
REQ-008 SHALL read the indexed word combinationally when EX/MEM mem_read=1, then capture it into MEM/WB on the same edge; load latency input->data_2_write_87 = 2 edges.
REQ-009 SHALL, at each edge, load MEM/WB with: reg_2_write_87 = EX/MEM wreg; data_2_write_87 = read data if mem_to_reg else alu_out; en_wb_87 = reg_write AND (wreg != 0).
REQ-010 SHALL treat mem_read and mem_write both set as a write only; read data ignored, MEM/WB data = alu_out.
REQ-011 SHALL ensure a load issued the cycle after a store to the same word returns the stored value (write completes before next read).
REQ-012 SHALL hold memory contents unchanged on cycles with mem_write=0.

Reset
REQ-013 SHALL on rst_87 assertion immediately clear EX/MEM and MEM/WB registers and mem_err_87 to 0; thus pc_src_87, fwd_en_87, en_wb_87 = 0 and all data outputs = 0.
REQ-014 SHALL leave data-memory contents unaffected by reset.
REQ-015 SHALL, with reset asserted mid-operation, suppress any pending store (cleared mem_write) and drop in-flight writebacks.
REQ-016 SHALL resume capture on the first rising edge after rst_87 deasserts.

Configuration
REQ-017 SHALL support macro MEM_ALIGN_CHK_EN.
- Defined: access with mem_read or mem_write and alu_out[1:0] != 0 suppresses the write, forces MEM/WB data to 0, and sets mem_err_87 (sticky until reset).
- Not defined: alu_out[1:0] ignored; mem_err_87 tied 0.

Verification
REQ-018 Store/load: sw 0xDEADBEEF to addr 0x10, next cycle lw addr 0x10 wreg=5 -> two edges later en_wb_87=1, reg_2_write_87=5, data_2_write_87=0xDEADBEEF.
REQ-019 R-type: alu_out=0x1234, reg_write=1, mem_to_reg=0, wreg=3 -> fwd_en_87=1 after 1 edge; writeback 0x1234 to r3 after 2 edges.
REQ-020 Branch: branch=1, zero=1, pc_brnch=0x40 -> pc_src_87=1, pc_tgt_87=0x40 one edge later; zero=0 -> pc_src_87=0.
REQ-021 r0 and wrap: wreg=0, reg_write=1 -> en_wb_87=0 and fwd_en_87=0; store at addr DEPTH*4+8 then load addr 8 -> stored value returned.
REQ-022 Reset mid-store: rst_87 asserted while EX/MEM mem_write=1 to addr 0x20 -> word 0x20 unchanged; all outputs 0 immediately.
REQ-023 MEM_ALIGN_CHK_EN defined: sw to addr 0x13 -> memory unchanged, mem_err_87=1 and held until reset; undefined: same store writes word 0x10, mem_err_87=0.

Source files
------------

// File: rtl/instr_mem_if.sv
// EX -> MEM stage bundle and MEM -> fetch/decode return signals.
// Groups the instr_mem datapath/control lines for the EX side and the MEM side.
interface instr_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] alu_out;
  logic [DATA_WIDTH-1:0] rval_b;
  logic [4:0]            wreg;
  logic                  reg_write;
  logic                  mem_to_reg;
  logic                  mem_read;
  logic                  mem_write;
  logic                  branch;
  logic                  zero;
  logic [ADDR_WIDTH-1:0] pc_brnch;
  logic                  pc_src;
  logic [ADDR_WIDTH-1:0] pc_tgt;
  logic [4:0]            fwd_reg;
  logic [DATA_WIDTH-1:0] fwd_val;
  logic                  fwd_en;
  logic [4:0]            reg_2_write;
  logic [DATA_WIDTH-1:0] data_2_write;
  logic                  en_wb;
  logic                  mem_err;

  modport master (
    output alu_out, rval_b, wreg, reg_write, mem_to_reg,
    output mem_read, mem_write, branch, zero, pc_brnch,
    input  pc_src, pc_tgt, fwd_reg, fwd_val, fwd_en,
    input  reg_2_write, data_2_write, en_wb, mem_err
  );

  modport slave (
    input  alu_out, rval_b, wreg, reg_write, mem_to_reg,
    input  mem_read, mem_write, branch, zero, pc_brnch,
    output pc_src, pc_tgt, fwd_reg, fwd_val, fwd_en,
    output reg_2_write, data_2_write, en_wb, mem_err
  );
endinterface

// File: rtl/instr_mem.sv
// MEM stage: EX/MEM register, word data memory, MEM/WB register.
// Optional misaligned-access trap enabled by macro MEM_ALIGN_CHK_EN.
module instr_mem #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_87,
  input  logic                  rst_87,
  input  logic [DATA_WIDTH-1:0] alu_out_87,
  input  logic [DATA_WIDTH-1:0] rval_b_87,
  input  logic [4:0]            wreg_87,
  input  logic                  reg_write_87,
  input  logic                  mem_to_reg_87,
  input  logic                  mem_read_87,
  input  logic                  mem_write_87,
  input  logic                  branch_87,
  input  logic                  zero_87,
  input  logic [ADDR_WIDTH-1:0] pc_brnch_87,
  output logic                  pc_src_87,
  output logic [ADDR_WIDTH-1:0] pc_tgt_87,
  output logic [4:0]            fwd_reg_87,
  output logic [DATA_WIDTH-1:0] fwd_val_87,
  output logic                  fwd_en_87,
  output logic [4:0]            reg_2_write_87,
  output logic [DATA_WIDTH-1:0] data_2_write_87,
  output logic                  en_wb_87,
  output logic                  mem_err_87
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] exm_alu_d, exm_alu_q;
  logic [DATA_WIDTH-1:0] exm_rvb_d, exm_rvb_q;
  logic [4:0]            exm_wreg_d, exm_wreg_q;
  logic                  exm_rw_d, exm_rw_q;
  logic                  exm_m2r_d, exm_m2r_q;
  logic                  exm_mr_d, exm_mr_q;
  logic                  exm_mw_d, exm_mw_q;
  logic                  exm_br_d, exm_br_q;
  logic                  exm_z_d, exm_z_q;
  logic [ADDR_WIDTH-1:0] exm_pcb_d, exm_pcb_q;

  logic [4:0]            wb_reg_d, wb_reg_q;
  logic [DATA_WIDTH-1:0] wb_data_d, wb_data_q;
  logic                  wb_en_d, wb_en_q;
  logic                  err_d, err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  misal;
  logic                  use_rd;

  assign idx = exm_alu_q[AW+1:2];

`ifdef MEM_ALIGN_CHK_EN
  assign misal = (exm_mr_q | exm_mw_q) & (exm_alu_q[1:0] != 2'b00);
  assign mem_err_87 = err_q;
`else
  assign misal = 1'b0;
  assign mem_err_87 = 1'b0;
`endif

  // a simultaneous write wins: the word is not returned as load data
  assign use_rd  = exm_m2r_q & exm_mr_q & ~exm_mw_q;
  assign rd_data = exm_mr_q ? mem[idx] : '0;

  assign pc_src_87  = exm_br_q & exm_z_q;
  assign pc_tgt_87  = exm_pcb_q;
  assign fwd_reg_87 = exm_wreg_q;
  assign fwd_val_87 = exm_alu_q;
  assign fwd_en_87  = exm_rw_q & ~exm_m2r_q & (exm_wreg_q != 5'd0);

  assign reg_2_write_87  = wb_reg_q;
  assign data_2_write_87 = wb_data_q;
  assign en_wb_87        = wb_en_q;

  // next-state for EX/MEM and MEM/WB
  always_comb begin
    exm_alu_d  = alu_out_87;
    exm_rvb_d  = rval_b_87;
    exm_wreg_d = wreg_87;
    exm_rw_d   = reg_write_87;
    exm_m2r_d  = mem_to_reg_87;
    exm_mr_d   = mem_read_87;
    exm_mw_d   = mem_write_87;
    exm_br_d   = branch_87;
    exm_z_d    = zero_87;
    exm_pcb_d  = pc_brnch_87;
    wb_reg_d   = exm_wreg_q;
    wb_en_d    = exm_rw_q & (exm_wreg_q != 5'd0);
    wb_data_d  = use_rd ? rd_data : exm_alu_q;
    if (misal) wb_data_d = '0;
    err_d      = err_q | misal;
  end

  // pipeline registers, cleared immediately on reset
  always_ff @(posedge clk_87 or posedge rst_87) begin
    if (rst_87) begin
      exm_alu_q  <= '0;
      exm_rvb_q  <= '0;
      exm_wreg_q <= '0;
      exm_rw_q   <= 1'b0;
      exm_m2r_q  <= 1'b0;
      exm_mr_q   <= 1'b0;
      exm_mw_q   <= 1'b0;
      exm_br_q   <= 1'b0;
      exm_z_q    <= 1'b0;
      exm_pcb_q  <= '0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      wb_en_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      exm_alu_q  <= exm_alu_d;
      exm_rvb_q  <= exm_rvb_d;
      exm_wreg_q <= exm_wreg_d;
      exm_rw_q   <= exm_rw_d;
      exm_m2r_q  <= exm_m2r_d;
      exm_mr_q   <= exm_mr_d;
      exm_mw_q   <= exm_mw_d;
      exm_br_q   <= exm_br_d;
      exm_z_q    <= exm_z_d;
      exm_pcb_q  <= exm_pcb_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      wb_en_q    <= wb_en_d;
      err_q      <= err_d;
    end
  end

  // data memory store; contents survive reset, stores blocked while in reset
  always_ff @(posedge clk_87) begin
    if (!rst_87 && exm_mw_q && !misal) begin
      mem[idx] <= exm_rvb_q;
    end
  end
endmodule

// File: tb/tb_instr_mem.sv
// Randomized scoreboard bench for instr_mem.
// Reference model: word array plus sticky error flag, evaluated in issue order.
module tb_instr_mem;
  localparam int DEPTH = 256;
  localparam int DW    = 32;
  localparam int AW    = 32;
`ifdef MEM_ALIGN_CHK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_87         (clk),
    .rst_87         (rst),
    .alu_out_87     (bus.alu_out),
    .rval_b_87      (bus.rval_b),
    .wreg_87        (bus.wreg),
    .reg_write_87   (bus.reg_write),
    .mem_to_reg_87  (bus.mem_to_reg),
    .mem_read_87    (bus.mem_read),
    .mem_write_87   (bus.mem_write),
    .branch_87      (bus.branch),
    .zero_87        (bus.zero),
    .pc_brnch_87    (bus.pc_brnch),
    .pc_src_87      (bus.pc_src),
    .pc_tgt_87      (bus.pc_tgt),
    .fwd_reg_87     (bus.fwd_reg),
    .fwd_val_87     (bus.fwd_val),
    .fwd_en_87      (bus.fwd_en),
    .reg_2_write_87 (bus.reg_2_write),
    .data_2_write_87(bus.data_2_write),
    .en_wb_87       (bus.en_wb),
    .mem_err_87     (bus.mem_err)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rvb;
    logic [4:0]  wreg;
    logic rw, m2r, mr, mw, br, z;
    logic [31:0] pcb;
  } txn_t;

  typedef struct {
    logic        src;
    logic [31:0] tgt;
    logic [4:0]  freg;
    logic [31:0] fval;
    logic        fen;
  } e1_t;

  typedef struct {
    logic [4:0]  wreg;
    logic [31:0] data;
    logic        en;
    logic        err;
  } e2_t;

  int total = 0;
  int bad = 0;
  logic [31:0] mdl [DEPTH];
  bit mdl_err = 1'b0;
  bit issued = 1'b0;
  bit v1, v2;
  e1_t q1[$];
  e2_t q2[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic txn_t nop();
    txn_t t;
    t.alu = 0; t.rvb = 0; t.wreg = 0; t.rw = 0; t.m2r = 0;
    t.mr = 0; t.mw = 0; t.br = 0; t.z = 0; t.pcb = 0;
    return t;
  endfunction

  function automatic txn_t mk_alu(logic [31:0] v, logic [4:0] r);
    txn_t t = nop();
    t.alu = v; t.wreg = r; t.rw = 1;
    return t;
  endfunction

  function automatic txn_t mk_ld(logic [31:0] a, logic [4:0] r);
    txn_t t = nop();
    t.alu = a; t.wreg = r; t.rw = 1; t.m2r = 1; t.mr = 1;
    return t;
  endfunction

  function automatic txn_t mk_st(logic [31:0] a, logic [31:0] d);
    txn_t t = nop();
    t.alu = a; t.rvb = d; t.mw = 1;
    return t;
  endfunction

  function automatic txn_t mk_br(logic [31:0] p, logic zz);
    txn_t t = nop();
    t.br = 1; t.z = zz; t.pcb = p;
    return t;
  endfunction

  task automatic drive(txn_t t);
    bus.alu_out    = t.alu;
    bus.rval_b     = t.rvb;
    bus.wreg       = t.wreg;
    bus.reg_write  = t.rw;
    bus.mem_to_reg = t.m2r;
    bus.mem_read   = t.mr;
    bus.mem_write  = t.mw;
    bus.branch     = t.br;
    bus.zero       = t.z;
    bus.pc_brnch   = t.pcb;
  endtask

  // Model: outputs one edge later from the EX fields, writeback a further edge.
  task automatic issue(txn_t t);
    e1_t a;
    e2_t b;
    int  w;
    bit  mis;
    @(negedge clk);
    drive(t);
    w = int'((t.alu >> 2) % DEPTH);
    mis = ALN && (t.mr || t.mw) && (t.alu % 4 != 0);
    a.src  = t.br && t.z;
    a.tgt  = t.pcb;
    a.freg = t.wreg;
    a.fval = t.alu;
    a.fen  = t.rw && !t.m2r && (t.wreg != 0);
    b.wreg = t.wreg;
    b.en   = t.rw && (t.wreg != 0);
    if (mis) b.data = 0;
    else if (t.m2r && t.mr && !t.mw) b.data = mdl[w];
    else b.data = t.alu;
    mdl_err = mdl_err | mis;
    b.err = mdl_err;
    if (t.mw && !mis) mdl[w] = t.rvb;
    q1.push_back(a);
    q2.push_back(b);
    issued = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      drive(nop());
      issued = 1'b0;
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".pc_src"}, 32'(bus.pc_src), 0);
    chk({tag, ".pc_tgt"}, bus.pc_tgt, 0);
    chk({tag, ".fwd_reg"}, 32'(bus.fwd_reg), 0);
    chk({tag, ".fwd_val"}, bus.fwd_val, 0);
    chk({tag, ".fwd_en"}, 32'(bus.fwd_en), 0);
    chk({tag, ".wb_reg"}, 32'(bus.reg_2_write), 0);
    chk({tag, ".wb_data"}, bus.data_2_write, 0);
    chk({tag, ".en_wb"}, 32'(bus.en_wb), 0);
    chk({tag, ".mem_err"}, 32'(bus.mem_err), 0);
  endtask

  // Tracks which edges present a tracked transaction at each output stage.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= issued;
      v2 <= v1;
    end
  end

  // Monitor: compares presented outputs against queued expectations.
  always @(negedge clk) begin
    e1_t a;
    e2_t b;
    if (!rst && v1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL q1 underflow");
      end else begin
        a = q1.pop_front();
        chk("pc_src", 32'(bus.pc_src), 32'(a.src));
        chk("pc_tgt", bus.pc_tgt, a.tgt);
        chk("fwd_reg", 32'(bus.fwd_reg), 32'(a.freg));
        chk("fwd_val", bus.fwd_val, a.fval);
        chk("fwd_en", 32'(bus.fwd_en), 32'(a.fen));
      end
    end
    if (!rst && v2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL q2 underflow");
      end else begin
        b = q2.pop_front();
        chk("wb_reg", 32'(bus.reg_2_write), 32'(b.wreg));
        chk("wb_data", bus.data_2_write, b.data);
        chk("en_wb", 32'(bus.en_wb), 32'(b.en));
        chk("mem_err", 32'(bus.mem_err), 32'(b.err));
      end
    end
  end

  initial begin
    txn_t t;
    drive(nop());
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      issue(mk_st(i * 4, $urandom()));
    end

    issue(mk_st(32'h10, 32'hDEADBEEF));
    issue(mk_ld(32'h10, 5'd5));
    issue(mk_alu(32'h1234, 5'd3));
    issue(mk_br(32'h40, 1'b1));
    issue(mk_br(32'h40, 1'b0));
    issue(mk_alu(32'h55AA, 5'd0));
    issue(mk_st(DEPTH * 4 + 8, 32'hC0FFEE01));
    issue(mk_ld(32'h8, 5'd8));
    issue(mk_st(32'h13, 32'h13131313));
    issue(mk_ld(32'h10, 5'd10));
    idle(2);

    for (int n = 0; n < 2000; n++) begin
      int k;
      int w;
      logic [31:0] a;
      k = $urandom_range(0, 5);
      w = $urandom_range(0, DEPTH - 1);
      a = 32'($urandom_range(0, 15) * DEPTH * 4 + w * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      case (k)
        0: t = mk_alu($urandom(), 5'($urandom()));
        1: t = mk_ld(a, 5'($urandom()));
        2: t = mk_st(a, $urandom());
        3: begin
          t = mk_ld(a, 5'($urandom()));
          t.mw = 1; t.rvb = $urandom();
        end
        4: t = mk_br($urandom(), 1'($urandom()));
        default: t = mk_alu($urandom(), 5'd0);
      endcase
      if (k != 4) begin
        t.br = 1'($urandom()); t.z = 1'($urandom()); t.pcb = $urandom();
      end
      issue(t);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    @(negedge clk);
    t = mk_st(32'h20, 32'h0BADF00D);
    t.rw = 1; t.wreg = 5'd7; t.br = 1; t.z = 1; t.pcb = 32'h1234;
    drive(t);
    issued = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    mdl_err = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    drive(nop());
    @(negedge clk);
    rst = 1'b0;
    issue(mk_ld(32'h20, 5'd9));
    issue(mk_alu(32'h77, 5'd1));
    idle(4);

    chk("drain", 32'(q1.size() + q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
